// File: rtl/dmem_lane_sequencer.sv
// Load/store sequencer for the 4-bank byte-lane data memory: single-read loads with
// extension, and stores swept across offsets -3..N-1 so every bank receives every byte.
module dmem_lane_sequencer #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_BITS    = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_raddress,
    output logic [31:0] mem_waddress,
    output logic [31:0] mem_datain,
    output logic [3:0]  mem_wr,
    input  logic [31:0] mem_dataout
);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
            $error("dmem_lane_sequencer: READ_LATENCY must be 1..3");
        end
        if (ADDR_BITS < 2 || ADDR_BITS > 32) begin : g_bad_addr_bits
            $error("dmem_lane_sequencer: ADDR_BITS must be 2..32");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ_WAIT   = 2'd1,
        WRITE_SWEEP = 2'd2,
        RESP        = 2'd3
    } state_t;

    state_t             state;
    logic [1:0]         size_q;
    logic [2:0]         n_q;
    logic               uns_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic signed [3:0]  offset;
    logic [1:0]         wait_cnt;

    logic [2:0]         req_n;
    logic signed [3:0]  next_offset;
    logic signed [3:0]  last_offset;
    logic [35:0]        first_lanes;
    logic [35:0]        next_lanes;

    function automatic logic [2:0] byte_count(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            2'd0:    n = 3'd1;
            2'd1:    n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Returns {mem_wr, mem_datain}: bank k writes byte d+k of wdata when that byte exists.
    function automatic logic [35:0] sweep_lanes(input logic signed [3:0] d,
                                                input logic [2:0] n,
                                                input logic [31:0] wdata);
        logic [3:0]        m;
        logic [31:0]       dat;
        logic signed [4:0] j;
        m   = 4'b0000;
        dat = 32'h0000_0000;
        for (int k = 0; k < 4; k++) begin
            j = $signed({d[3], d}) + $signed(5'(k));
            if (j >= 5'sd0 && j < $signed({2'b00, n})) begin
                m[k]            = 1'b1;
                dat[8*k +: 8]   = wdata[{j[1:0], 3'b000} +: 8];
            end else begin
                m[k]            = 1'b0;
                dat[8*k +: 8]   = 8'h00;
            end
        end
        return {m, dat};
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                                input logic [1:0] size,
                                                input logic uns);
        logic [31:0] r;
        case (size)
            2'd0:    r = {{24{~uns & raw[7]}}, raw[7:0]};
            2'd1:    r = {{16{~uns & raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Lane patterns for the first sweep cycle and for the offset that follows the current one.
    always_comb begin
        req_n       = byte_count(req_size);
        next_offset = offset + 4'sd1;
        last_offset = $signed({1'b0, n_q - 3'd1});
        first_lanes = sweep_lanes(-4'sd3, req_n, req_wdata);
        next_lanes  = sweep_lanes(next_offset, n_q, wdata_q);
    end

    // Control FSM with all outputs registered; write strobes and response default to idle each cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= 32'h0000_0000;
            mem_raddress <= 32'h0000_0000;
            mem_waddress <= 32'h0000_0000;
            mem_datain   <= 32'h0000_0000;
            mem_wr       <= 4'b0000;
            size_q       <= 2'd0;
            n_q          <= 3'd1;
            uns_q        <= 1'b0;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            offset       <= 4'sd0;
            wait_cnt     <= 2'd0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            mem_wr     <= 4'b0000;
            mem_datain <= 32'h0000_0000;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        size_q    <= req_size;
                        n_q       <= req_n;
                        uns_q     <= req_unsigned;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        if (req_size == 2'd3) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (!req_we) begin
                            state        <= READ_WAIT;
                            mem_raddress <= req_addr;
                            wait_cnt     <= 2'd0;
                        end else begin
                            state        <= WRITE_SWEEP;
                            offset       <= -4'sd3;
                            mem_waddress <= req_addr - 32'd3;
                            mem_wr       <= first_lanes[35:32];
                            mem_datain   <= first_lanes[31:0];
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                READ_WAIT: begin
                    if (wait_cnt == 2'(READ_LATENCY - 1)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_extend(mem_dataout, size_q, uns_q);
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                WRITE_SWEEP: begin
                    if (offset == last_offset) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        offset       <= next_offset;
                        mem_waddress <= addr_q + {{28{next_offset[3]}}, next_offset};
                        mem_wr       <= next_lanes[35:32];
                        mem_datain   <= next_lanes[31:0];
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lane_sequencer.sv
// Bench for dmem_lane_sequencer: a 4-bank memory model behind the DUT plus a flat byte-array
// reference of what software stored; loads are predicted from the flat array.
module tb_dmem_lane_sequencer;

    localparam int RL = 1;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_raddress;
    logic [31:0] mem_waddress;
    logic [31:0] mem_datain;
    logic [3:0]  mem_wr;
    logic [31:0] mem_dataout;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] bank [4][65536];
    logic [7:0] ref_mem [65536];

    dmem_lane_sequencer #(.READ_LATENCY(RL), .ADDR_BITS(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_raddress(mem_raddress), .mem_waddress(mem_waddress),
        .mem_datain(mem_datain), .mem_wr(mem_wr), .mem_dataout(mem_dataout)
    );

    always #5 Clk = ~Clk;

    // Banked memory: bank k serves raddress+k and is written at waddress+k.
    always @(posedge Clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_wr[k]) bank[k][16'(mem_waddress + 32'(k))] <= mem_datain[8*k +: 8];
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) mem_dataout[8*k +: 8] = bank[k][16'(mem_raddress + 32'(k))];
    end

    function automatic logic [7:0] init_byte(input int a);
        logic [15:0] w;
        w = 16'(a);
        return w[7:0] ^ w[15:8] ^ 8'h5A;
    endfunction

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    // Expected load value assembled from the flat reference with plain arithmetic.
    function automatic logic [31:0] expected_load(input logic [31:0] addr, input logic [1:0] size,
                                                  input logic uns);
        longint v;
        int n;
        n = nbytes(size);
        v = 0;
        for (int j = 0; j < n; j++) v = v + (longint'(ref_mem[16'(addr + 32'(j))]) << (8 * j));
        if (!uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_accept(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int waited;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL accept_wait: req_ready=%b after %0d cycles, required 1", req_ready, waited);
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size);
        int n;
        int d;
        int j;
        logic [3:0] exp_wr;
        logic [31:0] exp_data;
        n = nbytes(size);
        do_accept(1'b1, size, 1'b0, addr, wdata);
        for (int i = 0; i < n + 3; i++) begin
            d = i - 3;
            exp_wr = 4'b0000;
            exp_data = 32'h0;
            for (int k = 0; k < 4; k++) begin
                j = d + k;
                if (j >= 0 && j < n) begin
                    exp_wr[k] = 1'b1;
                    exp_data[8*k +: 8] = wdata[8*j +: 8];
                end
            end
            compared++;
            if (mem_wr !== exp_wr || mem_datain !== exp_data || mem_waddress !== 32'(addr + 32'(d))
                || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL store_sweep[%0d] @%h: wr=%b data=%h waddr=%h rv=%b rdy=%b, required wr=%b data=%h waddr=%h rv=0 rdy=0",
                         i, addr, mem_wr, mem_datain, mem_waddress, resp_valid, req_ready,
                         exp_wr, exp_data, 32'(addr + 32'(d)));
            end
            tick();
        end
        compared++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0 || mem_wr !== 4'b0000) begin
            mismatched++;
            $display("FAIL store_resp @%h: rv=%b err=%b rdata=%h wr=%b, required 1 0 00000000 0000",
                     addr, resp_valid, resp_err, resp_rdata, mem_wr);
        end
        tick();
        compared++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL store_done @%h: rv=%b rdy=%b, required 0 1", addr, resp_valid, req_ready);
        end
        for (int jj = 0; jj < n; jj++) ref_mem[16'(addr + 32'(jj))] = wdata[8*jj +: 8];
    endtask

    task automatic run_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                            output logic [31:0] got);
        logic [31:0] exp;
        exp = expected_load(addr, size, uns);
        do_accept(1'b0, size, uns, addr, 32'h0);
        for (int i = 0; i < RL; i++) begin
            compared++;
            if (resp_valid !== 1'b0 || mem_wr !== 4'b0000 || mem_raddress !== addr) begin
                mismatched++;
                $display("FAIL load_wait @%h: rv=%b wr=%b raddr=%h, required 0 0000 %h",
                         addr, resp_valid, mem_wr, mem_raddress, addr);
            end
            tick();
        end
        got = resp_rdata;
        compared++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== exp) begin
            mismatched++;
            $display("FAIL load_resp @%h size=%0d uns=%b: rv=%b err=%b rdata=%h, required 1 0 %h",
                     addr, size, uns, resp_valid, resp_err, resp_rdata, exp);
        end
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        compared++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0
            || mem_wr !== 4'b0000 || mem_raddress !== 32'h0 || mem_waddress !== 32'h0 || mem_datain !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_state: rdy=%b rv=%b err=%b rdata=%h wr=%b ra=%h wa=%h din=%h, required all idle/zero",
                     req_ready, resp_valid, resp_err, resp_rdata, mem_wr, mem_raddress, mem_waddress, mem_datain);
        end
    endtask

    task automatic test_word_store();
        logic [3:0] wr_seq [7];
        logic [31:0] got;
        wr_seq = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
        do_accept(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF);
        for (int i = 0; i < 7; i++) begin
            compared++;
            if (mem_wr !== wr_seq[i]) begin
                mismatched++;
                $display("FAIL sw_wr_seq[%0d]: mem_wr=%b, required %b", i, mem_wr, wr_seq[i]);
            end
            tick();
        end
        compared++;
        if (resp_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL sw_latency: resp_valid=%b at accept+8, required 1", resp_valid);
        end
        tick();
        for (int j = 0; j < 4; j++) ref_mem[16'h100 + j] = 8'(32'hDEAD_BEEF >> (8 * j));
        run_load(32'h100, 2'd2, 1'b0, got);
        compared++;
        if (got !== 32'hDEAD_BEEF) begin
            mismatched++;
            $display("FAIL lw_100: rdata=%h, required deadbeef", got);
        end
        run_load(32'h0FF, 2'd2, 1'b0, got);
        run_load(32'h101, 2'd2, 1'b0, got);
        run_load(32'h101, 2'd0, 1'b1, got);
        compared++;
        if (got !== 32'h0000_00BE) begin
            mismatched++;
            $display("FAIL lbu_101: rdata=%h, required 000000be", got);
        end
        run_load(32'h102, 2'd0, 1'b0, got);
        compared++;
        if (got !== 32'hFFFF_FFAD) begin
            mismatched++;
            $display("FAIL lb_102: rdata=%h, required ffffffad", got);
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] got;
        run_store(32'h200, 32'h0000_0080, 2'd0);
        run_load(32'h200, 2'd0, 1'b0, got);
        compared++;
        if (got !== 32'hFFFF_FF80) begin
            mismatched++;
            $display("FAIL lb_200: rdata=%h, required ffffff80", got);
        end
        run_load(32'h200, 2'd0, 1'b1, got);
        compared++;
        if (got !== 32'h0000_0080) begin
            mismatched++;
            $display("FAIL lbu_200: rdata=%h, required 00000080", got);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got;
        run_store(32'h0000_FFFF, 32'h0000_7FFF, 2'd1);
        run_load(32'h0000_FFFF, 2'd1, 1'b0, got);
        compared++;
        if (got !== 32'h0000_7FFF) begin
            mismatched++;
            $display("FAIL lh_ffff: rdata=%h, required 00007fff", got);
        end
    endtask

    task automatic test_illegal();
        do_accept(1'b1, 2'd3, 1'b0, 32'h300, 32'h1234_5678);
        compared++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 || mem_wr !== 4'b0000) begin
            mismatched++;
            $display("FAIL illegal_resp: rv=%b err=%b rdata=%h wr=%b, required 1 1 00000000 0000",
                     resp_valid, resp_err, resp_rdata, mem_wr);
        end
        tick();
        compared++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_wr !== 4'b0000) begin
            mismatched++;
            $display("FAIL illegal_after: rv=%b rdy=%b wr=%b, required 0 1 0000", resp_valid, req_ready, mem_wr);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] exp1;
        logic [31:0] exp2;
        exp1 = expected_load(32'h100, 2'd2, 1'b0);
        exp2 = expected_load(32'h200, 2'd0, 1'b0);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h100;
        tick();
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            compared++;
            if (req_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL b2b_busy: req_ready=%b at accept+%0d, required 0", req_ready, lat);
            end
            tick();
            lat++;
        end
        compared++;
        if (lat != RL + 1 || resp_rdata !== exp1 || req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_first: latency=%0d rdata=%h rdy=%b, required %0d %h 0",
                     lat, resp_rdata, req_ready, RL + 1, exp1);
        end
        req_addr = 32'h200; req_size = 2'd0;
        tick();
        compared++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_ready: rdy=%b rv=%b after resp, required 1 0", req_ready, resp_valid);
        end
        tick();
        req_valid = 1'b0;
        compared++;
        if (req_ready !== 1'b0 || mem_raddress !== 32'h200) begin
            mismatched++;
            $display("FAIL b2b_second_accept: rdy=%b raddr=%h, required 0 00000200", req_ready, mem_raddress);
        end
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        compared++;
        if (resp_valid !== 1'b1 || resp_rdata !== exp2) begin
            mismatched++;
            $display("FAIL b2b_second: rv=%b rdata=%h, required 1 %h", resp_valid, resp_rdata, exp2);
        end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        do_accept(1'b1, 2'd2, 1'b0, 32'h300, 32'h1122_3344);
        tick();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        compared++;
        if (mem_wr !== 4'b0000 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_sweep: wr=%b rv=%b rdy=%b, required 0000 0 1", mem_wr, resp_valid, req_ready);
        end
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (resp_valid !== 1'b0 || mem_wr !== 4'b0000) begin
                mismatched++;
                $display("FAIL reset_no_resp[%0d]: rv=%b wr=%b, required 0 0000", i, resp_valid, mem_wr);
            end
            tick();
        end
        run_store(32'h300, 32'h1122_3344, 2'd2);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] got;
        logic [1:0] size;
        for (int i = 0; i < 80; i++) begin
            addr = (($urandom_range(0, 3) == 0) ? 32'h0000_FFFC : 32'h0000_0400) + 32'($urandom_range(0, 11));
            size = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) run_store(addr, $urandom, size);
            else run_load(addr, size, 1'($urandom_range(0, 1)), got);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            ref_mem[a] = init_byte(a);
            for (int k = 0; k < 4; k++) bank[k][a] = init_byte(a);
        end
        #1;
        test_reset();
        test_word_store();
        test_byte_store();
        test_wrap();
        test_illegal();
        test_back_to_back();
        test_reset_mid_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
